// File: rtl/exc_pkg.sv
// Shared definitions for the exception controller: FSM state encoding and
// exception-syndrome codes.
package exc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HANDLER = 2'd1,
        LOCKUP  = 2'd2
    } exc_state_e;

    localparam logic [3:0] ESR_NONE  = 4'b0000;
    localparam logic [3:0] ESR_IRQ   = 4'b0001;
    localparam logic [3:0] ESR_INVOP = 4'b0010;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/exc_ctrl.sv
// Exception / interrupt controller: takes synchronous faults and external IRQs,
// saves return state, handles ERET and escalates nested faults to lockup.
module exc_ctrl
    import exc_pkg::*;
#(
    parameter logic [63:0] VECTOR_ADDR = 64'h0000_0000_0000_00D8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  EStatus,
    input  logic        ExtIRQ,
    input  logic        ERet,
    input  logic [63:0] PC,
    output logic        Exc,
    output logic [63:0] ExcVector,
    output logic        ERetTake,
    output logic [63:0] ELR,
    output logic [3:0]  ESR,
    output logic        ExtIAck,
    output logic        InHandler,
    output logic        Lockup,
    output logic [7:0]  ExcCount
);

    exc_state_e state;
    logic       irq_pend;
    logic       sync_exc;
    logic       irq_take;

    assign sync_exc  = (EStatus != ESR_NONE);
    assign Exc       = !reset && (state == IDLE) && (sync_exc || irq_pend);
    // A sync fault wins the take; the IRQ stays pending behind it.
    assign irq_take  = Exc && !sync_exc;
    assign ERetTake  = !reset && (state == HANDLER) && ERet && !sync_exc;
    assign ExcVector = VECTOR_ADDR;
    assign InHandler = (state == HANDLER);
    assign Lockup    = (state == LOCKUP);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            irq_pend <= 1'b0;
            ELR      <= '0;
            ESR      <= ESR_NONE;
            ExcCount <= '0;
            ExtIAck  <= 1'b0;
        end else begin
            ExtIAck <= irq_take;
            if (irq_take)
                irq_pend <= 1'b0;
            else if (ExtIRQ)
                irq_pend <= 1'b1;

            case (state)
                IDLE: begin
                    if (Exc) begin
                        ELR      <= PC;
                        ESR      <= sync_exc ? EStatus : ESR_IRQ;
                        ExcCount <= sat_inc8(ExcCount);
                        state    <= HANDLER;
                    end
                end
                HANDLER: begin
                    if (sync_exc)
                        state <= LOCKUP;
                    else if (ERet)
                        state <= IDLE;
                end
                LOCKUP:  state <= LOCKUP;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
